exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter MUL_LAT, default 4, meaning: cycles canExecuteOut is held for a multiply-class op; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inValidIn  input  1  register-read stage presents an instruction.
REQ-005 inReadyOut  output  1  sequencer accepts an instruction this cycle.
REQ-006 opcodeIn  input  [0:7]  primary opcode of the presented instruction.
REQ-007 opcodeLengthIn  input  [0:31]  opcode byte count (1 or 2).
REQ-008 hasExtendedOpcodeIn  input  [0:31]  nonzero means the ModRM reg field is an opcode extension.
REQ-009 extendedOpcodeIn  input  [0:2]  opcode extension value.
REQ-010 operand1ValValidIn, operand2ValValidIn  input  1 each  live operand-ready flags from the register file/bypass.
REQ-011 flushIn  input  1  discard the held instruction (redirect).
REQ-012 outReadyIn  input  1  writeback accepts a result.
REQ-013 latchEnOut  output  1  load enable for the execute-stage pipeline register.
REQ-014 canExecuteOut  output  1  drives the execute datapath canExecuteIn.
REQ-015 outValidOut  output  1  result valid toward writeback.
REQ-016 busyOut  output  1  high in any state other than IDLE.
REQ-017 haltOut  output  1  sticky halt indication.
REQ-018 stateOut  output  [0:2]  current state encoding, for debug.
REQ-019 retiredCountOut  output  [0:31]  count of completed instructions.

Function
REQ-020 States SHALL be IDLE, WAIT_OPND, EXEC, MULTI, HOLD, HALT.
REQ-021 inReadyOut SHALL be 1 only in IDLE with flushIn=0; accept = inValidIn & inReadyOut; latchEnOut = accept.
REQ-022 On accept, the opcode fields SHALL be captured internally and classified: HALT-class = length 1 and opcode C3/CB/CF; MUL-class = length 1 F7 ext 100 or 101, length 1 6B or 69, length 2 AF; all others single-cycle.
REQ-023 After accept: HALT-class -> HALT; otherwise -> WAIT_OPND if either operand valid input is 0 in the accept cycle, else EXEC (single) or MULTI (MUL-class).
REQ-024 WAIT_OPND SHALL leave for EXEC or MULTI in the first cycle both operand valid inputs are 1; no timeout.
REQ-025 EXEC: canExecuteOut=1 and outValidOut=1 for that cycle; outReadyIn=1 -> IDLE with retire; else -> HOLD.
REQ-026 MULTI: a down-counter loaded with MUL_LAT-1 on entry; canExecuteOut=1 every cycle; outValidOut=1 only when counter=0; at counter=0 with outReadyIn=1 -> IDLE with retire, outReadyIn=0 -> HOLD.
REQ-027 HOLD: canExecuteOut=1, outValidOut=1 until outReadyIn=1, then -> IDLE with retire.
REQ-028 Retire SHALL increment retiredCountOut by 1, wrapping FFFFFFFF -> 0.
REQ-029 flushIn=1 in any state except HALT SHALL force IDLE next cycle, suppress outValidOut, canExecuteOut and retire in that cycle, and block accept.
REQ-030 HALT: haltOut=1, inReadyOut=0, canExecuteOut=0, outValidOut=0; flushIn ignored; exit only by reset.
REQ-031 Single-cycle op with operands ready and outReadyIn=1 SHALL complete in 1 cycle after accept; MUL-class in MUL_LAT cycles.

Reset
REQ-032 reset=1 at a clock edge SHALL, in any state including mid-MULTI and HALT, set state IDLE, counter 0, retiredCountOut 0, haltOut 0, and drop the held instruction.
REQ-033 During and one cycle after reset deassertion, outputs SHALL read IDLE values: inReadyOut=1 (after reset low), all other 1-bit outputs 0, stateOut=IDLE encoding 0.

Structure
REQ-034 Package exec_ctrl_pkg SHALL hold the state enum, op-class enum, MUL_LAT default and opcode constants (C3, CB, CF, F7, 6B, 69, AF).
REQ-035 Op classification SHALL be a combinational sub-module exec_op_classify, instantiated once.

Verification
REQ-036 ADD 01, operands valid, outReadyIn=1: accept at cycle 0 -> canExecuteOut and outValidOut at cycle 1, IDLE at cycle 2, retiredCountOut=1.
REQ-037 F7 ext 100, MUL_LAT=4: canExecuteOut cycles 1-4, outValidOut only cycle 4, retire at cycle 4.
REQ-038 operand2ValValidIn=0 for 3 cycles after accepting 29: WAIT_OPND cycles 1-3, EXEC at cycle 4.
REQ-039 outReadyIn=0 for 2 cycles after EXEC: HOLD with outValidOut=1, retire on third cycle; flushIn in MULTI cycle 2 -> IDLE, count unchanged.
REQ-040 C3 accepted -> haltOut=1 sticky, inValidIn and flushIn ignored 10 cycles; reset -> IDLE, haltOut=0, count=0.
REQ-041 Preload count FFFFFFFF via 2^32-1 retires or force, one more retire -> 0.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_ctrl_pkg : shared types and opcode constants for the          |
// |                 execute-stage sequencer. Rev 1.0                   |
// +--------------------------------------------------------------------+
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_OPND = 3'd1,
    ST_EXEC      = 3'd2,
    ST_MULTI     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_HALT   = 2'd2
  } op_class_e;

  localparam int unsigned MUL_LAT_DEFAULT = 4;
  localparam int unsigned CNT_W           = 4;

  localparam logic [7:0] OPC_RET     = 8'hC3;
  localparam logic [7:0] OPC_RETF    = 8'hCB;
  localparam logic [7:0] OPC_IRET    = 8'hCF;
  localparam logic [7:0] OPC_GRP3    = 8'hF7;
  localparam logic [7:0] OPC_IMUL_IB = 8'h6B;
  localparam logic [7:0] OPC_IMUL_IZ = 8'h69;
  localparam logic [7:0] OPC_IMUL_2B = 8'hAF;

  localparam logic [2:0] EXT_MUL  = 3'b100;
  localparam logic [2:0] EXT_IMUL = 3'b101;

endpackage
`default_nettype wire

// File: rtl/exec_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_sequencer_if : register-read / execute / writeback handshake  |
// |                     bundle for exec_sequencer. Rev 1.0             |
// +--------------------------------------------------------------------+
interface exec_sequencer_if;

  logic        inValidIn;
  logic        inReadyOut;
  logic [0:7]  opcodeIn;
  logic [0:31] opcodeLengthIn;
  logic [0:31] hasExtendedOpcodeIn;
  logic [0:2]  extendedOpcodeIn;
  logic        operand1ValValidIn;
  logic        operand2ValValidIn;
  logic        flushIn;
  logic        outReadyIn;
  logic        latchEnOut;
  logic        canExecuteOut;
  logic        outValidOut;
  logic        busyOut;
  logic        haltOut;
  logic [0:2]  stateOut;
  logic [0:31] retiredCountOut;

  modport master (
    output inValidIn, opcodeIn, opcodeLengthIn, hasExtendedOpcodeIn,
           extendedOpcodeIn, operand1ValValidIn, operand2ValValidIn,
           flushIn, outReadyIn,
    input  inReadyOut, latchEnOut, canExecuteOut, outValidOut, busyOut,
           haltOut, stateOut, retiredCountOut
  );

  modport slave (
    input  inValidIn, opcodeIn, opcodeLengthIn, hasExtendedOpcodeIn,
           extendedOpcodeIn, operand1ValValidIn, operand2ValValidIn,
           flushIn, outReadyIn,
    output inReadyOut, latchEnOut, canExecuteOut, outValidOut, busyOut,
           haltOut, stateOut, retiredCountOut
  );

endinterface
`default_nettype wire

// File: rtl/exec_op_classify.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_op_classify : combinational opcode classifier (halt / multi-  |
// |                    cycle multiply / single-cycle). Rev 1.0         |
// +--------------------------------------------------------------------+
module exec_op_classify
  import exec_ctrl_pkg::*;
(
  input  logic [0:7]  i_opcode,
  input  logic [0:31] i_opcode_len,
  input  logic [0:31] i_has_ext,
  input  logic [0:2]  i_ext,
  output op_class_e   o_class
);

  logic w_len1;
  logic w_len2;
  logic w_is_halt;
  logic w_is_grp3_mul;
  logic w_is_mul;

  assign w_len1 = (i_opcode_len == 32'd1);
  assign w_len2 = (i_opcode_len == 32'd2);

  assign w_is_halt = w_len1 && ((i_opcode == OPC_RET) ||
                                (i_opcode == OPC_RETF) ||
                                (i_opcode == OPC_IRET));

  // Group-3 F7 is only a multiply when its ModRM extension selects MUL/IMUL
  assign w_is_grp3_mul = (i_opcode == OPC_GRP3) && (i_has_ext != 32'd0) &&
                         ((i_ext == EXT_MUL) || (i_ext == EXT_IMUL));

  assign w_is_mul = (w_len1 && (w_is_grp3_mul ||
                                (i_opcode == OPC_IMUL_IB) ||
                                (i_opcode == OPC_IMUL_IZ))) ||
                    (w_len2 && (i_opcode == OPC_IMUL_2B));

  always_comb begin
    o_class = CLS_SINGLE;
    if (w_is_halt) begin
      o_class = CLS_HALT;
    end else if (w_is_mul) begin
      o_class = CLS_MUL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_sequencer : issue/execute/writeback control FSM with operand  |
// |                  wait, multi-cycle multiply and sticky halt. Rev 1.0|
// +--------------------------------------------------------------------+
module exec_sequencer
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  exec_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_WAIT  = ST_WAIT_OPND;
  localparam logic [2:0] S_EXEC  = ST_EXEC;
  localparam logic [2:0] S_MULTI = ST_MULTI;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_HALT  = ST_HALT;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MUL_LAT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_mul;
  logic [31:0]      r_retired;

  logic [2:0]       w_next;
  op_class_e        w_cls;
  logic             w_live;
  logic             w_ready;
  logic             w_accept;
  logic             w_ops_ok;
  logic             w_active;
  logic             w_result;
  logic             w_retire;

  exec_op_classify u_classify (
    .i_opcode     (bus.opcodeIn),
    .i_opcode_len (bus.opcodeLengthIn),
    .i_has_ext    (bus.hasExtendedOpcodeIn),
    .i_ext        (bus.extendedOpcodeIn),
    .o_class      (w_cls)
  );

  // Outputs present IDLE values while reset is held, whatever the state
  assign w_live   = !reset;
  assign w_ready  = w_live && (r_state == S_IDLE) && !bus.flushIn;
  assign w_accept = w_ready && bus.inValidIn;
  assign w_ops_ok = bus.operand1ValValidIn && bus.operand2ValValidIn;
  assign w_active = w_live && !bus.flushIn &&
                    ((r_state == S_EXEC) || (r_state == S_MULTI) || (r_state == S_HOLD));
  assign w_result = w_active && ((r_state != S_MULTI) || (r_cnt == '0));
  assign w_retire = w_result && bus.outReadyIn;

  assign bus.inReadyOut      = w_ready;
  assign bus.latchEnOut      = w_accept;
  assign bus.canExecuteOut   = w_active;
  assign bus.outValidOut     = w_result;
  assign bus.busyOut         = w_live && (r_state != S_IDLE);
  assign bus.haltOut         = w_live && (r_state == S_HALT);
  assign bus.stateOut        = w_live ? r_state : S_IDLE;
  assign bus.retiredCountOut = r_retired;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cls == CLS_HALT) begin
            w_next = S_HALT;
          end else if (!w_ops_ok) begin
            w_next = S_WAIT;
          end else if (w_cls == CLS_MUL) begin
            w_next = S_MULTI;
          end else begin
            w_next = S_EXEC;
          end
        end
      end
      S_WAIT: begin
        if (w_ops_ok) begin
          w_next = r_is_mul ? S_MULTI : S_EXEC;
        end
      end
      S_EXEC:  w_next = bus.outReadyIn ? S_IDLE : S_HOLD;
      S_MULTI: begin
        if (r_cnt == '0) begin
          w_next = bus.outReadyIn ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.outReadyIn) begin
          w_next = S_IDLE;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    // A redirect overrides everything except a halted core
    if (bus.flushIn && (r_state != S_HALT)) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_mul  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_MULTI) begin
        r_cnt <= (r_state == S_MULTI) ? (r_cnt - 1'b1) : LAT_LOAD;
      end else begin
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_is_mul <= (w_cls == CLS_MUL);
      end else if (w_next == S_IDLE) begin
        r_is_mul <= 1'b0;
      end
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exec_sequencer : vector table, directed corner sequences and    |
// |                     random traffic against a transaction model.    |
// +--------------------------------------------------------------------+
module tb_exec_sequencer;

  localparam int MUL_LAT = 4;

  typedef struct {
    bit         rst;
    bit         vld;
    logic [7:0] opc;
    int         len;
    bit         hasx;
    logic [2:0] ext;
    bit         op1;
    bit         op2;
    bit         flush;
    bit         ordy;
  } stim_t;

  typedef struct {
    logic [7:0] opc;
    int         len;
    logic [2:0] ext;
    int         exp_lat;   // 0 = halts the core
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  // Transaction-level model of the sequencer
  bit          m_halted;
  bit          m_held;
  bit          m_pending;
  bit          m_is_mul;
  int          m_lat_left;
  logic [31:0] m_count;

  // DUT outputs captured by the most recent step
  bit          g_can;
  bit          g_ov;
  bit          g_halt;
  bit          g_rdy;
  logic [2:0]  g_state;
  logic [31:0] g_cnt;

  logic [7:0] pool [0:7] = '{8'h01, 8'h29, 8'hF7, 8'hF7, 8'h6B, 8'h69, 8'hAF, 8'h31};
  logic [7:0] hpool [0:2] = '{8'hC3, 8'hCB, 8'hCF};
  vec_t       vt [0:12];

  exec_sequencer_if bus ();

  exec_sequencer #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_halt_op(input stim_t s);
    return (s.len == 1) && (s.opc == 8'hC3 || s.opc == 8'hCB || s.opc == 8'hCF);
  endfunction

  function automatic bit is_mul_op(input stim_t s);
    if (s.len == 1 && s.opc == 8'hF7 && s.hasx && (s.ext == 3'd4 || s.ext == 3'd5)) return 1'b1;
    if (s.len == 1 && (s.opc == 8'h6B || s.opc == 8'h69)) return 1'b1;
    if (s.len == 2 && s.opc == 8'hAF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, vld: 1'b0, opc: 8'h00, len: 1, hasx: 1'b0, ext: 3'd0,
          op1: 1'b1, op2: 1'b1, flush: 1'b0, ordy: 1'b1};
    return s;
  endfunction

  function automatic stim_t issue(input logic [7:0] opc, input int len, input logic [2:0] ext);
    stim_t s;
    s      = idle();
    s.vld  = 1'b1;
    s.opc  = opc;
    s.len  = len;
    s.ext  = ext;
    s.hasx = (opc == 8'hF7);
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s       = idle();
    s.rst   = ($urandom_range(0, 39) == 0);
    s.vld   = $urandom_range(0, 1) == 1;
    s.opc   = ($urandom_range(0, 24) == 0) ? hpool[$urandom_range(0, 2)] : pool[$urandom_range(0, 7)];
    s.len   = ($urandom_range(0, 3) == 0) ? 2 : 1;
    s.hasx  = 1'b1;
    s.ext   = 3'($urandom_range(0, 7));
    s.op1   = $urandom_range(0, 3) != 0;
    s.op2   = $urandom_range(0, 3) != 0;
    s.flush = $urandom_range(0, 15) == 0;
    s.ordy  = $urandom_range(0, 9) < 6;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    reset                   = s.rst;
    bus.inValidIn           = s.vld;
    bus.opcodeIn            = s.opc;
    bus.opcodeLengthIn      = s.len;
    bus.hasExtendedOpcodeIn = 32'(s.hasx);
    bus.extendedOpcodeIn    = s.ext;
    bus.operand1ValValidIn  = s.op1;
    bus.operand2ValValidIn  = s.op2;
    bus.flushIn             = s.flush;
    bus.outReadyIn          = s.ordy;
  endtask

  task automatic model_update(input stim_t s);
    if (s.rst) begin
      m_halted = 0; m_held = 0; m_pending = 0; m_is_mul = 0; m_lat_left = 0; m_count = '0;
    end else if (m_halted) begin
      // only reset leaves a halt
    end else if (s.flush) begin
      m_held = 0; m_pending = 0;
    end else if (m_held) begin
      if (m_pending) begin
        if (s.op1 && s.op2) begin
          m_pending  = 0;
          m_lat_left = m_is_mul ? MUL_LAT - 1 : 0;
        end
      end else if (m_lat_left > 0) begin
        m_lat_left--;
      end else if (s.ordy) begin
        m_held  = 0;
        m_count = m_count + 32'd1;
      end
    end else if (s.vld) begin
      if (is_halt_op(s)) begin
        m_halted = 1;
      end else begin
        m_held     = 1;
        m_is_mul   = is_mul_op(s);
        m_pending  = !(s.op1 && s.op2);
        m_lat_left = m_is_mul ? MUL_LAT - 1 : 0;
      end
    end
  endtask

  task automatic step(input stim_t s);
    bit live, rdy, act, ov, busy;
    @(negedge clk);
    apply(s);
    #1;
    live = !s.rst;
    rdy  = live && !m_halted && !m_held && !s.flush;
    act  = live && m_held && !m_pending && !s.flush;
    ov   = act && (m_lat_left == 0);
    busy = live && (m_halted || m_held);
    chk("inReadyOut", bus.inReadyOut, rdy);
    chk("latchEnOut", bus.latchEnOut, rdy && s.vld);
    chk("canExecuteOut", bus.canExecuteOut, act);
    chk("outValidOut", bus.outValidOut, ov);
    chk("busyOut", bus.busyOut, busy);
    chk("haltOut", bus.haltOut, live && m_halted);
    chk("stateOut_is_idle", bus.stateOut == 3'd0, !busy);
    if (!s.rst) chk("retiredCountOut", bus.retiredCountOut, m_count);
    g_can   = bus.canExecuteOut;
    g_ov    = bus.outValidOut;
    g_halt  = bus.haltOut;
    g_rdy   = bus.inReadyOut;
    g_state = bus.stateOut;
    g_cnt   = bus.retiredCountOut;
    @(posedge clk);
    model_update(s);
  endtask

  task automatic do_reset();
    stim_t s;
    s     = idle();
    s.rst = 1'b1;
    step(s);
    step(s);
    step(idle());
  endtask

  initial begin
    stim_t s;
    int    got;
    logic [31:0] base;
    n_checks = 0;
    n_errors = 0;
    m_count  = '0;
    apply(idle());
    reset = 1'b1;

    vt[0]  = '{8'h01, 1, 3'd0, 1};
    vt[1]  = '{8'hC3, 1, 3'd0, 0};
    vt[2]  = '{8'hCB, 1, 3'd0, 0};
    vt[3]  = '{8'hCF, 1, 3'd0, 0};
    vt[4]  = '{8'hC3, 2, 3'd0, 1};
    vt[5]  = '{8'hF7, 1, 3'd4, MUL_LAT};
    vt[6]  = '{8'hF7, 1, 3'd5, MUL_LAT};
    vt[7]  = '{8'hF7, 1, 3'd6, 1};
    vt[8]  = '{8'h6B, 1, 3'd0, MUL_LAT};
    vt[9]  = '{8'h69, 1, 3'd0, MUL_LAT};
    vt[10] = '{8'hAF, 2, 3'd0, MUL_LAT};
    vt[11] = '{8'hAF, 1, 3'd0, 1};
    vt[12] = '{8'h6B, 2, 3'd0, 1};

    // Reset state
    do_reset();
    chk("reset_ready", g_rdy, 1);
    chk("reset_state", g_state, 0);
    chk("reset_count", g_cnt, 0);

    // Classification table: cycles from accept to retire
    for (int i = 0; i < 13; i++) begin
      do_reset();
      step(issue(vt[i].opc, vt[i].len, vt[i].ext));
      #1;
      got = -1;
      if (bus.haltOut) got = 0;
      for (int n = 1; n <= 20 && got < 0; n++) begin
        step(idle());
        #1;
        if (bus.retiredCountOut == 32'd1) got = n;
      end
      chk($sformatf("latency_vec%0d_op%0h", i, vt[i].opc), got, vt[i].exp_lat);
    end

    // ADD: execute in cycle 1, idle with one retire in cycle 2
    do_reset();
    step(issue(8'h01, 1, 3'd0));
    step(idle());
    chk("add_c1_can", g_can, 1);
    chk("add_c1_ov", g_ov, 1);
    step(idle());
    chk("add_c2_state", g_state, 0);
    chk("add_c2_count", g_cnt, 1);

    // Multiply: canExecute cycles 1..MUL_LAT, result only in the last
    do_reset();
    step(issue(8'hF7, 1, 3'd4));
    for (int c = 1; c <= MUL_LAT + 1; c++) begin
      step(idle());
      chk($sformatf("mul_c%0d_can", c), g_can, (c <= MUL_LAT));
      chk($sformatf("mul_c%0d_ov", c), g_ov, (c == MUL_LAT));
    end
    chk("mul_count", g_cnt, 1);

    // Operand wait: op2 low in cycles 0..2, executes in cycle 4
    do_reset();
    s = issue(8'h29, 1, 3'd0);
    s.op2 = 1'b0;
    step(s);
    for (int c = 1; c <= 4; c++) begin
      s = idle();
      s.op2 = (c >= 3);
      step(s);
      chk($sformatf("wait_c%0d_can", c), g_can, (c == 4));
      chk($sformatf("wait_c%0d_busy", c), g_state != 0, 1);
    end

    // Writeback stall: result held two cycles, retired on the third
    do_reset();
    step(issue(8'h01, 1, 3'd0));
    for (int c = 1; c <= 3; c++) begin
      s = idle();
      s.ordy = (c == 3);
      step(s);
      chk($sformatf("hold_c%0d_ov", c), g_ov, 1);
      chk($sformatf("hold_c%0d_count", c), g_cnt, 0);
    end
    step(idle());
    chk("hold_retired", g_cnt, 1);

    // Flush in the second multiply cycle discards the op
    base = m_count;
    step(issue(8'h69, 1, 3'd0));
    step(idle());
    s = idle();
    s.flush = 1'b1;
    step(s);
    chk("flush_can", g_can, 0);
    chk("flush_ov", g_ov, 0);
    step(idle());
    chk("flush_state", g_state, 0);
    chk("flush_count", g_cnt, base);

    // Halt is sticky against new requests and flush; reset clears it
    step(issue(8'hC3, 1, 3'd0));
    for (int c = 0; c < 10; c++) begin
      s = issue(8'h01, 1, 3'd0);
      s.flush = 1'b1;
      step(s);
      chk("halt_sticky", g_halt, 1);
      chk("halt_no_ready", g_rdy, 0);
    end
    do_reset();
    chk("halt_cleared", g_halt, 0);
    chk("halt_reset_count", g_cnt, 0);
    chk("halt_reset_state", g_state, 0);

    // Retired count wraps from all-ones to zero
    @(negedge clk);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_count = 32'hFFFF_FFFF;
    step(idle());
    chk("wrap_preload", g_cnt, 32'hFFFF_FFFF);
    step(issue(8'h01, 1, 3'd0));
    step(idle());
    step(idle());
    chk("wrap_zero", g_cnt, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(rnd());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
